// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte FIFO feeding an LSB-first serialiser on rs232_tx_o.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int CLK_DIV = 16,
    parameter int FIFO_AW = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       rs232_tx_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   w_divNext;
    logic [2:0]         r_bitIdx;
    logic [2:0]         w_bitNext;
    logic [7:0]         r_shift;
    logic [7:0]         w_shiftNext;
    logic               r_tx;
    logic               w_txNext;
    logic               r_busy;
    logic               w_busyNext;
`ifdef UART_TX_PARITY_EN
    logic               r_par;
    logic               w_parNext;
`endif

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [FIFO_AW:0]   w_countNext;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_divLast;
    logic [7:0]         w_head;

    // ready_o looks only at the registered count, so a pop on the same edge never admits a push into a full FIFO.
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_push    = valid_i && !w_full;
    assign w_divLast = (r_div == DIV_LAST);
    assign w_head    = r_mem[r_rptr];

    assign ready_o    = !w_full;
    assign busy_o     = r_busy;
    assign rs232_tx_o = r_tx;

    always_comb begin
        w_countNext = r_count;
        case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + 1'b1;
            2'b01:   w_countNext = r_count - 1'b1;
            default: w_countNext = r_count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_countNext;
        end
    end

    // The divider restarts on every state entry and on every data-bit advance.
    always_comb begin
        w_stateNext = r_state;
        w_divNext   = r_div;
        w_bitNext   = r_bitIdx;
        w_shiftNext = r_shift;
        w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parNext   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_divNext = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shiftNext = w_head;
`ifdef UART_TX_PARITY_EN
                    w_parNext   = ^w_head;
`endif
                    w_stateNext = S_START;
                end
            end
            S_START: begin
                if (w_divLast) begin
                    w_divNext   = '0;
                    w_bitNext   = 3'd0;
                    w_stateNext = S_DATA;
                end else begin
                    w_divNext = r_div + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (w_divLast) begin
                    w_divNext   = '0;
                    w_shiftNext = {1'b0, r_shift[7:1]};
                    if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_stateNext = S_PARITY;
`else
                        w_stateNext = S_STOP;
`endif
                    end else begin
                        w_bitNext = r_bitIdx + 3'd1;
                    end
                end else begin
                    w_divNext = r_div + DIV_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_divLast) begin
                    w_divNext   = '0;
                    w_stateNext = S_STOP;
                end else begin
                    w_divNext = r_div + DIV_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_divLast) begin
                    w_divNext = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shiftNext = w_head;
`ifdef UART_TX_PARITY_EN
                        w_parNext   = ^w_head;
`endif
                        w_stateNext = S_START;
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end else begin
                    w_divNext = r_div + DIV_W'(1);
                end
            end
            default: begin
                w_divNext   = '0;
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Line level and busy are computed from the next state so both come straight from flops.
    always_comb begin
        w_txNext = 1'b1;
        case (w_stateNext)
            S_START:  w_txNext = 1'b0;
            S_DATA:   w_txNext = w_shiftNext[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txNext = w_parNext;
`endif
            default:  w_txNext = 1'b1;
        endcase
        w_busyNext = (w_stateNext != S_IDLE) || (w_countNext != '0);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_stateNext;
            r_div    <= w_divNext;
            r_bitIdx <= w_bitNext;
            r_shift  <= w_shiftNext;
            r_tx     <= w_txNext;
            r_busy   <= w_busyNext;
`ifdef UART_TX_PARITY_EN
            r_par    <= w_parNext;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: scoreboard of pushed bytes checked by a line-level frame monitor.
module tb_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CLK_DIV;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic       busy_o;
    logic       rs232_tx_o;

    int         testsRun = 0;
    int         failCount = 0;
    int         cycleCnt = 0;
    bit         monActive = 1'b0;
    logic [7:0] sbQ [$];
    int         startCycles [$];

    uart_tx #(
        .CLK_DIV(CLK_DIV),
        .FIFO_AW(FIFO_AW)
    ) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .rs232_tx_o(rs232_tx_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one byte for one edge; the scoreboard takes it only if the handshake completes.
    task automatic applyStimulus(input logic [7:0] b, input logic expReady);
        logic wasReady;
        @(negedge clk_i);
        data_i   = b;
        valid_i  = 1'b1;
        wasReady = ready_o;
        checkOutput("readyBeforePush", 32'(ready_o), 32'(expReady));
        @(posedge clk_i);
        if (wasReady) sbQ.push_back(b);
    endtask

    function automatic logic frameBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        else if (idx == 9) return ^b;
`endif
        else return 1'b1;
    endfunction

    // Frame monitor: samples mid-bit and compares each decoded byte with the scoreboard head.
    initial begin : monitor
        logic [7:0] rx;
        logic [7:0] expB;
        logic       parBit;
        rx = 8'h00;
        parBit = 1'b0;
        forever begin
            @(negedge clk_i);
            if (monActive && rstn_i && rs232_tx_o === 1'b0) begin
                startCycles.push_back(cycleCnt);
                repeat (CLK_DIV/2) @(negedge clk_i);
                checkOutput("startBit", 32'(rs232_tx_o), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk_i);
                    rx[i] = rs232_tx_o;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CLK_DIV) @(negedge clk_i);
                parBit = rs232_tx_o;
`endif
                repeat (CLK_DIV) @(negedge clk_i);
                checkOutput("stopBit", 32'(rs232_tx_o), 32'd1);
                expB = (sbQ.size() > 0) ? sbQ.pop_front() : 8'hxx;
                checkOutput("rxByte", 32'(rx), 32'(expB));
`ifdef UART_TX_PARITY_EN
                checkOutput("parityBit", 32'(parBit), 32'(^expB));
`endif
                repeat (CLK_DIV - CLK_DIV/2 - 1) @(negedge clk_i);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL globalTimeout: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int waitN;
        logic wasReady;

        // Reset and idle line
        repeat (3) @(negedge clk_i);
        checkOutput("resetLine", 32'(rs232_tx_o), 32'd1);
        checkOutput("resetReady", 32'(ready_o), 32'd1);
        checkOutput("resetBusy", 32'(busy_o), 32'd0);
        rstn_i = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            checkOutput("idleLine", 32'(rs232_tx_o), 32'd1);
            checkOutput("idleReady", 32'(ready_o), 32'd1);
            checkOutput("idleBusy", 32'(busy_o), 32'd0);
        end
        monActive = 1'b1;

        // Single frame with exact bit timing
        applyStimulus(8'hA5, 1'b1);
        @(negedge clk_i);
        valid_i = 1'b0;
        checkOutput("latencyLineStillHigh", 32'(rs232_tx_o), 32'd1);
        for (int b = 0; b < FRAME_CYC; b++) begin
            @(negedge clk_i);
            checkOutput("frameA5Bit", 32'(rs232_tx_o), 32'(frameBit(8'hA5, b / CLK_DIV)));
            checkOutput("frameA5Busy", 32'(busy_o), 32'd1);
        end
        @(negedge clk_i);
        checkOutput("busyAfterFrame", 32'(busy_o), 32'd0);
        checkOutput("lineAfterFrame", 32'(rs232_tx_o), 32'd1);

        // Back-to-back, FIFO full, push held off across the pop edge
        startCycles.delete();
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1);
        @(negedge clk_i);
        data_i = 8'h66;
        valid_i = 1'b1;
        checkOutput("readyWhenFull", 32'(ready_o), 32'd0);
        waitN = 0;
        while (ready_o !== 1'b1 && waitN < 1000) begin
            @(negedge clk_i);
            waitN++;
        end
        checkOutput("fullHoldCycles", 32'(waitN), 32'(FRAME_CYC - 3));
        wasReady = ready_o;
        @(posedge clk_i);
        if (wasReady) sbQ.push_back(8'h66);
        @(negedge clk_i);
        valid_i = 1'b0;

`ifdef UART_TX_PARITY_EN
        applyStimulus(8'h07, 1'b1);
        @(negedge clk_i);
        valid_i = 1'b0;
`endif

        waitN = 0;
        while ((sbQ.size() != 0 || busy_o !== 1'b0) && waitN < 3000) begin
            @(negedge clk_i);
            waitN++;
        end
        checkOutput("drainQueue", 32'(sbQ.size()), 32'd0);
        checkOutput("drainBusy", 32'(busy_o), 32'd0);
`ifdef UART_TX_PARITY_EN
        checkOutput("frameCount", 32'(startCycles.size()), 32'd7);
`else
        checkOutput("frameCount", 32'(startCycles.size()), 32'd6);
`endif
        for (int i = 1; i < startCycles.size(); i++) begin
            checkOutput("frameSpacing", 32'(startCycles[i] - startCycles[i-1]), 32'(FRAME_CYC));
        end

        // Reset during data bit 3 of 0xFF with more bytes queued
        monActive = 1'b0;
        sbQ.delete();
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (16) @(negedge clk_i);
        checkOutput("busyBeforeReset", 32'(busy_o), 32'd1);
        #1 rstn_i = 1'b0;
        #1;
        checkOutput("midResetLine", 32'(rs232_tx_o), 32'd1);
        checkOutput("midResetBusy", 32'(busy_o), 32'd0);
        checkOutput("midResetReady", 32'(ready_o), 32'd1);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            checkOutput("postResetLine", 32'(rs232_tx_o), 32'd1);
            checkOutput("postResetBusy", 32'(busy_o), 32'd0);
        end

        // Reset while the line is low must raise it at once
        applyStimulus(8'h00, 1'b1);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (6) @(negedge clk_i);
        checkOutput("lineLowBeforeReset", 32'(rs232_tx_o), 32'd0);
        #1 rstn_i = 1'b0;
        #1;
        checkOutput("lowResetLine", 32'(rs232_tx_o), 32'd1);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            checkOutput("postLowResetLine", 32'(rs232_tx_o), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter, the transmit-side counterpart of the chip8 UART receive path.
- Accepts bytes from core logic over a valid/ready handshake into a small FIFO and serialises them LSB-first on rs232_tx_o.
- Bit timing comes from an internal clock divider; no separate UART clock is required.
- Sits in top next to the receiver and drives the board RS-232 TX pin.

Parameters:
- CLK_DIV, 16, clk_i cycles per UART bit; legal range >= 2; counter width $clog2(CLK_DIV).
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4).

Ports:
- clk_i  input  1  system clock
- rstn_i  input  1  asynchronous active-low reset
- data_i  input  8  byte to transmit
- valid_i  input  1  data_i valid
- ready_o  output  1  FIFO can accept a byte (not full)
- busy_o  output  1  FIFO non-empty or frame in progress
- rs232_tx_o  output  1  serial line, idle high

Behaviour:
- Interface (already decided): one clock, clk_i; reset rstn_i is asynchronous and active-low. All state is cleared on the falling edge of rstn_i.
- Reset values:
  - rs232_tx_o=1, ready_o=1, busy_o=0.
  - FIFO empty; state IDLE; bit counter and divider =0.
  - Reset mid-frame: line returns high immediately; the partial frame and FIFO contents are discarded.
- Push:
  - A byte is accepted on a rising edge with valid_i && ready_o.
  - ready_o = !full, derived from the registered count only.
  - When full, a push is rejected even if a pop occurs on the same edge.
  - valid_i while ready_o=0 has no effect; data_i is not sampled.
- Pop: occurs only on the IDLE->START or STOP->START transition. A simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- Divider:
  - Counts 0..CLK_DIV-1 and restarts at every state entry.
  - Every bit is held exactly CLK_DIV cycles.
- State machine:
  - IDLE: rs232_tx_o=1. If FIFO non-empty, load the head into the shift register and go to START.
  - START: rs232_tx_o=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: rs232_tx_o=shift[0] for CLK_DIV cycles, then shift right and increment the index. After index 7 completes, go to STOP (or PARITY when enabled).
  - STOP: rs232_tx_o=1 for CLK_DIV cycles. At the end, go to START with a pop if the FIFO is non-empty, else go to IDLE.
- Latency: a byte pushed into an empty, idle block at edge N drives rs232_tx_o=0 from edge N+1.
- Back-to-back: frames are contiguous with no idle gap. Frame period is exactly 10*CLK_DIV cycles (11*CLK_DIV with parity).
- rs232_tx_o is driven directly from a flop (glitch-free).
- busy_o = (state!=IDLE) || !empty, registered. It deasserts on the same edge the last STOP completes with an empty FIFO.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - rs232_tx_o = even parity (XOR of the 8 data bits) for CLK_DIV cycles.
  - Frame is 11 bits.
- When undefined:
  - No PARITY state and no parity logic.
  - Frame is 10 bits, 8N1.

Test Plan:
- Reset, then idle: after rstn_i 0->1 with no push -> rs232_tx_o=1, ready_o=1, busy_o=0 for 1000 cycles.
- Single frame: CLK_DIV=4, push 0xA5 -> one cycle later the line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles). busy_o then drops and the line stays 1.
- Back-to-back/full: CLK_DIV=4, FIFO_AW=2.
  - Push 0x01,0x02,0x03,0x04,0x05 on consecutive cycles with valid_i held.
  - The first byte pops after one cycle, so 0x01..0x05 are all accepted and ready_o=0 once 4 bytes are queued.
  - A sixth push is held off until the first pop after that.
  - The frames then appear contiguously in order, at exactly 40-cycle spacing.
- Push on full plus pop: fill the FIFO, assert valid_i with 0x66 on the STOP->START pop edge -> 0x66 is not accepted that edge; it is accepted the next edge (ready_o=1).
- Reset mid-frame: assert rstn_i=0 during DATA bit 3 of 0xFF -> rs232_tx_o=1 immediately, FIFO empty. After release, no residual frame is sent.
- Parity (UART_TX_PARITY_EN):
  - Push 0xA5 -> parity bit 0, frame 44 cycles at CLK_DIV=4.
  - Push 0x07 -> parity bit 1.
